reg_xfer_seq: RTL and testbench

//  Multi-cycle sequencer that drives the control inputs of regSel (register OE/load decoder).

---
 rtl/reg_xfer_seq_pkg.sv | 66 ++++++
 rtl/reg_xfer_seq.sv | 174 +++++++++++++++++
 tb/tb_reg_xfer_seq.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_xfer_seq_pkg.sv
// ----------------------------------------------------------------------------
// reg_xfer_seq_pkg
// Shared definitions for the register-transfer sequencer:
//   - regSel bus-source and load-source select codes
//   - command opcode encodings
//   - sequencer state encoding (one state per micro-step plus IDLE)
//   - helper functions that map an opcode to its first micro-step and
//     each micro-step to its successor
// ----------------------------------------------------------------------------
package reg_xfer_seq_pkg;

    // Bus (OE) source select codes understood by regSel
    localparam logic [1:0] OE_SRC_USEQ = 2'd0;
    localparam logic [1:0] OE_SRC_OP0  = 2'd1;
    localparam logic [1:0] OE_SRC_OP1  = 2'd2;
    localparam logic [1:0] OE_SRC_OP2  = 2'd3;

    // Load sink select codes understood by regSel
    localparam logic LD_SRC_USEQ = 1'b0;
    localparam logic LD_SRC_OP0  = 1'b1;

    typedef enum logic [1:0] {
        OPC_MOV  = 2'b00,
        OPC_ALU  = 2'b01,
        OPC_SWAP = 2'b10,
        OPC_NOP  = 2'b11
    } opcode_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M1,
        ST_A1,
        ST_A2,
        ST_A3,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_N1
    } state_e;

    // First micro-step entered when a command is accepted
    function automatic state_e first_step(input opcode_e opc);
        state_e st;
        case (opc)
            OPC_MOV:  st = ST_M1;
            OPC_ALU:  st = ST_A1;
            OPC_SWAP: st = ST_S1;
            default:  st = ST_N1;
        endcase
        return st;
    endfunction

    // Successor of a micro-step; final steps fall back to IDLE
    function automatic state_e next_step(input state_e st);
        state_e nx;
        case (st)
            ST_A1:   nx = ST_A2;
            ST_A2:   nx = ST_A3;
            ST_S1:   nx = ST_S2;
            ST_S2:   nx = ST_S3;
            default: nx = ST_IDLE;
        endcase
        return nx;
    endfunction

endpackage

// File: rtl/reg_xfer_seq.sv
// ----------------------------------------------------------------------------
// reg_xfer_seq
// Multi-cycle sequencer driving the regSel OE/load decoder and the ALU
// operand latches. One command (MOV, ALU, SWAP, NOP) is accepted in IDLE,
// its operand fields are latched, and it is stepped through micro-cycles,
// each enabling at most one bus source and one bus sink.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   start          in   command request, sampled only in IDLE
//   opcode         in   00 MOV, 01 ALU, 10 SWAP, 11 NOP
//   op0/op1/op2    in   operand register fields
//   stall          in   freeze the current micro-step
//   oe, load       out  register bus OE / register load enable
//   oeSourceSel    out  0 useq, 1 op0, 2 op1, 3 op2
//   loadSourceSel  out  0 useq, 1 op0
//   useqRegSelOe   out  sequencer-supplied OE register index
//   useqRegSelLoad out  sequencer-supplied load register index
//   op0o/op1o/op2o out  latched operands
//   aluALoad/aluBLoad/aluOe out  ALU operand latch strobes / ALU result OE
//   busy           out  command in progress
//   done           out  final micro-step of a command
// ----------------------------------------------------------------------------
module reg_xfer_seq
    import reg_xfer_seq_pkg::*;
#(
    parameter int REG_W   = 3,
    parameter int TMP_REG = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [REG_W-1:0] op0,
    input  logic [REG_W-1:0] op1,
    input  logic [REG_W-1:0] op2,
    input  logic             stall,
    output logic             oe,
    output logic             load,
    output logic [1:0]       oeSourceSel,
    output logic             loadSourceSel,
    output logic [REG_W-1:0] useqRegSelOe,
    output logic [REG_W-1:0] useqRegSelLoad,
    output logic [REG_W-1:0] op0o,
    output logic [REG_W-1:0] op1o,
    output logic [REG_W-1:0] op2o,
    output logic             aluALoad,
    output logic             aluBLoad,
    output logic             aluOe,
    output logic             busy,
    output logic             done
);

    localparam logic [REG_W-1:0] TMP_IDX = REG_W'(TMP_REG);

    state_e           state_q, state_d;
    logic [REG_W-1:0] op0_q, op0_d;
    logic [REG_W-1:0] op1_q, op1_d;
    logic [REG_W-1:0] op2_q, op2_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op0_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    // Operands are captured only when a command is accepted, so a start
    // seen while busy cannot disturb the command in flight.
    always_comb begin
        state_d = state_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = first_step(opcode_e'(opcode));
                op0_d   = op0;
                op1_d   = op1;
                op2_d   = op2;
            end
        end else if (!stall) begin
            state_d = next_step(state_q);
        end
    end

    // Micro-step decode. Selects and indices are a function of state only,
    // so they stay put across a stall; only the strobes are suppressed.
    always_comb begin
        oe             = 1'b0;
        load           = 1'b0;
        oeSourceSel    = OE_SRC_USEQ;
        loadSourceSel  = LD_SRC_USEQ;
        useqRegSelOe   = '0;
        useqRegSelLoad = '0;
        aluALoad       = 1'b0;
        aluBLoad       = 1'b0;
        aluOe          = 1'b0;
        done           = 1'b0;
        case (state_q)
            ST_M1: begin
                oe            = 1'b1;
                oeSourceSel   = OE_SRC_OP1;
                load          = 1'b1;
                loadSourceSel = LD_SRC_OP0;
                done          = 1'b1;
            end
            ST_A1: begin
                oe          = 1'b1;
                oeSourceSel = OE_SRC_OP1;
                aluALoad    = 1'b1;
            end
            ST_A2: begin
                oe          = 1'b1;
                oeSourceSel = OE_SRC_OP2;
                aluBLoad    = 1'b1;
            end
            ST_A3: begin
                aluOe         = 1'b1;
                load          = 1'b1;
                loadSourceSel = LD_SRC_OP0;
                done          = 1'b1;
            end
            ST_S1: begin
                oe             = 1'b1;
                oeSourceSel    = OE_SRC_OP0;
                load           = 1'b1;
                useqRegSelLoad = TMP_IDX;
            end
            ST_S2: begin
                oe            = 1'b1;
                oeSourceSel   = OE_SRC_OP1;
                load          = 1'b1;
                loadSourceSel = LD_SRC_OP0;
            end
            ST_S3: begin
                // op1 is reached through the useq index because regSel can
                // only route a load to op0 or to the sequencer-supplied index.
                oe             = 1'b1;
                useqRegSelOe   = TMP_IDX;
                load           = 1'b1;
                useqRegSelLoad = op1_q;
                done           = 1'b1;
            end
            ST_N1: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        if (stall) begin
            oe       = 1'b0;
            load     = 1'b0;
            aluALoad = 1'b0;
            aluBLoad = 1'b0;
            aluOe    = 1'b0;
            done     = 1'b0;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign op0o = op0_q;
    assign op1o = op1_q;
    assign op2o = op2_q;

endmodule

// File: tb/tb_reg_xfer_seq.sv
// ----------------------------------------------------------------------------
// tb_reg_xfer_seq
// Self-checking bench for reg_xfer_seq. A behavioural regSel decoder turns
// the sequencer's selects into one-hot register OE/load vectors. Each vector
// row holds the inputs driven for one cycle and the outputs expected during
// that same cycle.
// ----------------------------------------------------------------------------
module tb_reg_xfer_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] opcode;
    logic [2:0] op0, op1, op2;
    logic       stall;
    logic       oe, load, loadSourceSel;
    logic [1:0] oeSourceSel;
    logic [2:0] useqRegSelOe, useqRegSelLoad, op0o, op1o, op2o;
    logic       aluALoad, aluBLoad, aluOe, busy, done;

    logic [2:0] oeIdx, ldIdx;
    logic [7:0] regOes, regLoads;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic       start;
        logic [1:0] opcode;
        logic [2:0] op0, op1, op2;
        logic       stall;
        logic       eBusy, eDone;
        logic [4:0] eStrb;      // {oe, load, aluALoad, aluBLoad, aluOe}
        logic [1:0] eOeSel;
        logic       eLdSel;
        logic [7:0] eRegOes, eRegLoads;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    reg_xfer_seq dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .opcode         (opcode),
        .op0            (op0),
        .op1            (op1),
        .op2            (op2),
        .stall          (stall),
        .oe             (oe),
        .load           (load),
        .oeSourceSel    (oeSourceSel),
        .loadSourceSel  (loadSourceSel),
        .useqRegSelOe   (useqRegSelOe),
        .useqRegSelLoad (useqRegSelLoad),
        .op0o           (op0o),
        .op1o           (op1o),
        .op2o           (op2o),
        .aluALoad       (aluALoad),
        .aluBLoad       (aluBLoad),
        .aluOe          (aluOe),
        .busy           (busy),
        .done           (done)
    );

    // Downstream regSel decoder model
    assign oeIdx    = (oeSourceSel == 2'd0) ? useqRegSelOe :
                      (oeSourceSel == 2'd1) ? op0o :
                      (oeSourceSel == 2'd2) ? op1o : op2o;
    assign ldIdx    = loadSourceSel ? op0o : useqRegSelLoad;
    assign regOes   = oe   ? (8'h01 << oeIdx) : 8'h00;
    assign regLoads = load ? (8'h01 << ldIdx) : 8'h00;

    function automatic vec_t mkVec(
        input logic       st,
        input logic [1:0] opc,
        input logic [2:0] a, b, c,
        input logic       stl,
        input logic       bsy, dn,
        input logic [4:0] strb,
        input logic [1:0] oeSel,
        input logic       ldSel,
        input logic [7:0] oes, loads
    );
        vec_t v;
        v.start = st;   v.opcode = opc;
        v.op0 = a;      v.op1 = b;      v.op2 = c;
        v.stall = stl;
        v.eBusy = bsy;  v.eDone = dn;   v.eStrb = strb;
        v.eOeSel = oeSel; v.eLdSel = ldSel;
        v.eRegOes = oes;  v.eRegLoads = loads;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        start  = v.start;
        opcode = v.opcode;
        op0    = v.op0;
        op1    = v.op1;
        op2    = v.op2;
        stall  = v.stall;
    endtask

    task automatic checkField(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkField({tag, ".busy"},     8'(busy), 8'(v.eBusy));
        checkField({tag, ".done"},     8'(done), 8'(v.eDone));
        checkField({tag, ".strobes"},  8'({oe, load, aluALoad, aluBLoad, aluOe}), 8'(v.eStrb));
        checkField({tag, ".oeSel"},    8'(oeSourceSel), 8'(v.eOeSel));
        checkField({tag, ".ldSel"},    8'(loadSourceSel), 8'(v.eLdSel));
        checkField({tag, ".regOes"},   regOes, v.eRegOes);
        checkField({tag, ".regLoads"}, regLoads, v.eRegLoads);
    endtask

    task automatic runVec(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t idleV;
        idleV = mkVec(0, 2'd0, 0, 0, 0, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00);

        // MOV op0=1 op1=3
        vecs.push_back(idleV);
        vecs.push_back(mkVec(1, 2'd0, 1, 3, 0, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 1, 5'b11000, 2'd2, 1, 8'h08, 8'h02));
        vecs.push_back(idleV);
        // ALU op0=2 op1=4 op2=5
        vecs.push_back(mkVec(1, 2'd1, 2, 4, 5, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 0, 5'b10100, 2'd2, 0, 8'h10, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 0, 5'b10010, 2'd3, 0, 8'h20, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 1, 5'b01001, 2'd0, 1, 8'h00, 8'h04));
        vecs.push_back(idleV);
        // SWAP op0=1 op1=6
        vecs.push_back(mkVec(1, 2'd2, 1, 6, 0, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 0, 5'b11000, 2'd1, 0, 8'h02, 8'h80));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 0, 5'b11000, 2'd2, 1, 8'h40, 8'h02));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 1, 5'b11000, 2'd0, 0, 8'h80, 8'h40));
        vecs.push_back(idleV);
        // NOP
        vecs.push_back(mkVec(1, 2'd3, 0, 0, 0, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 1, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(idleV);
        // ALU with two stall cycles on A2: five busy cycles in total
        vecs.push_back(mkVec(1, 2'd1, 2, 4, 5, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 0, 5'b10100, 2'd2, 0, 8'h10, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 1, 1, 0, 5'b00000, 2'd3, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 1, 1, 0, 5'b00000, 2'd3, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 0, 5'b10010, 2'd3, 0, 8'h20, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 1, 5'b01001, 2'd0, 1, 8'h00, 8'h04));
        vecs.push_back(idleV);
        // SWAP with op0==op1==3; MOV start held through the command is ignored
        vecs.push_back(mkVec(1, 2'd2, 3, 3, 0, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(1, 2'd0, 5, 2, 0, 0, 1, 0, 5'b11000, 2'd1, 0, 8'h08, 8'h80));
        vecs.push_back(mkVec(1, 2'd0, 5, 2, 0, 0, 1, 0, 5'b11000, 2'd2, 1, 8'h08, 8'h08));
        vecs.push_back(mkVec(1, 2'd0, 5, 2, 0, 0, 1, 1, 5'b11000, 2'd0, 0, 8'h80, 8'h08));
        vecs.push_back(idleV);
        // stall in IDLE does not block start: MOV op0=4 op1=7
        vecs.push_back(mkVec(1, 2'd0, 4, 7, 0, 1, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 1, 5'b11000, 2'd2, 1, 8'h80, 8'h10));
        vecs.push_back(idleV);
        // MOV with op0==op1==2
        vecs.push_back(mkVec(1, 2'd0, 2, 2, 0, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00));
        vecs.push_back(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 1, 5'b11000, 2'd2, 1, 8'h04, 8'h04));
        vecs.push_back(idleV);

        // Reset state
        reset = 1'b1;
        applyStimulus(idleV);
        @(negedge clk);
        checkOutput(idleV, "reset");
        checkField("reset.op0o", 8'(op0o), 8'h00);
        checkField("reset.op1o", 8'(op1o), 8'h00);
        checkField("reset.op2o", 8'(op2o), 8'h00);
        checkField("reset.useqOe", 8'(useqRegSelOe), 8'h00);
        checkField("reset.useqLoad", 8'(useqRegSelLoad), 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted in SWAP S2 drops the command immediately
        runVec(mkVec(1, 2'd2, 1, 6, 0, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00), "rst.start");
        runVec(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 0, 5'b11000, 2'd1, 0, 8'h02, 8'h80), "rst.S1");
        applyStimulus(idleV);
        @(negedge clk);
        checkOutput(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 0, 5'b11000, 2'd2, 1, 8'h40, 8'h02), "rst.S2");
        #2;
        reset = 1'b1;
        #1;
        checkOutput(idleV, "rst.async");
        checkField("rst.async.op0o", 8'(op0o), 8'h00);
        checkField("rst.async.op1o", 8'(op1o), 8'h00);
        checkField("rst.async.useqLoad", 8'(useqRegSelLoad), 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        runVec(idleV, "rst.idle");
        runVec(mkVec(1, 2'd0, 1, 3, 0, 0, 0, 0, 5'b00000, 2'd0, 0, 8'h00, 8'h00), "rst.movStart");
        runVec(mkVec(0, 2'd0, 0, 0, 0, 0, 1, 1, 5'b11000, 2'd2, 1, 8'h08, 8'h02), "rst.movM1");
        runVec(idleV, "rst.movIdle");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
